// File: rtl/cpu_stage_sequencer.sv
// cpu_stage_sequencer: multi-cycle fetch/decode/execute/memory/writeback control sequencer
module cpu_stage_sequencer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             halt_req,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   input  logic             cond_pass,
   input  logic             dec_is_branch,
   input  logic             dec_is_mem,
   input  logic             dec_is_load,
   input  logic             dec_writes_rd,
   input  logic             dec_set_flags,
   output logic             fetch_en,
   output logic             decode_en,
   output logic             exec_en,
   output logic             mem_en,
   output logic             mem_read_not_write,
   output logic             wb_en,
   output logic             rf_write_en,
   output logic             cpsr_write_en,
   output logic             pc_inc,
   output logic             pc_branch,
   output logic [2:0]       state,
   output logic             fault,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] retire_count
);
   typedef enum logic [2:0] {
      IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXECUTE = 3'd3,
      MEMORY = 3'd4, WRITEBACK = 3'd5, FAULT = 3'd7
   } stateT;
   stateT curState, nextState;
   logic isBranch, isMem, isLoad, writesRd, setFlags, skip, inWb;
   logic [7:0] waitCnt;
   always_ff @(posedge clk or negedge nreset)
      if (!nreset) begin
         curState <= IDLE;
         {isBranch, isMem, isLoad, writesRd, setFlags} <= '0;
         waitCnt <= '0;
         cycle_count <= '0;
         retire_count <= '0;
      end else begin
         curState <= nextState;
         if (curState == DECODE)
            {isBranch, isMem, isLoad, writesRd, setFlags} <= {dec_is_branch, dec_is_mem, dec_is_load, dec_writes_rd, dec_set_flags};
         waitCnt <= (curState == MEMORY && !dmem_ready) ? waitCnt + 8'd1 : '0;
         if (curState != IDLE && curState != FAULT) cycle_count <= cycle_count + CNT_W'(1);
         if (skip || inWb) retire_count <= retire_count + CNT_W'(1);
      end
   always_comb begin
      nextState = curState;
      skip = curState == EXECUTE && !cond_pass;
      inWb = curState == WRITEBACK;
      case (curState)
         IDLE:      nextState = halt_req ? IDLE : FETCH;
         FETCH:     nextState = imem_ready ? DECODE : FETCH;
         DECODE:    nextState = EXECUTE;
         EXECUTE:   nextState = !cond_pass ? (halt_req ? IDLE : FETCH) : isMem ? MEMORY : WRITEBACK;
         MEMORY:    nextState = dmem_ready ? WRITEBACK : (int'(waitCnt) + 1 >= MEM_TIMEOUT) ? FAULT : MEMORY;
         WRITEBACK: nextState = halt_req ? IDLE : FETCH;
         default:   nextState = FAULT;
      endcase
   end
   assign fetch_en = curState == FETCH;
   assign decode_en = curState == DECODE;
   assign exec_en = curState == EXECUTE;
   assign mem_en = curState == MEMORY;
   assign mem_read_not_write = mem_en && isLoad;
   assign wb_en = inWb;
   // a store never writes the register file; memory ops never touch the flags
   assign rf_write_en = inWb && writesRd && !(isMem && !isLoad);
   assign cpsr_write_en = inWb && setFlags && !isMem;
   assign pc_branch = inWb && isBranch;
   assign pc_inc = skip || (inWb && !isBranch);
   assign state = curState;
   assign fault = curState == FAULT;
endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// tb_cpu_stage_sequencer: randomized instruction-level checking of cpu_stage_sequencer
module tb_cpu_stage_sequencer;
   localparam int TO = 15;
   localparam logic [10:0] F = 11'h400, D = 11'h200, E = 11'h100, M = 11'h080, MR = 11'h040,
      W = 11'h020, RF = 11'h010, CP = 11'h008, PI = 11'h004, PB = 11'h002, FL = 11'h001;
   logic clk = 0, nreset = 0;
   logic halt_req, imem_ready, dmem_ready, cond_pass;
   logic dec_is_branch, dec_is_mem, dec_is_load, dec_writes_rd, dec_set_flags;
   logic fetch_en, decode_en, exec_en, mem_en, mem_read_not_write, wb_en;
   logic rf_write_en, cpsr_write_en, pc_inc, pc_branch, fault;
   logic [2:0] state;
   logic [15:0] cycle_count, retire_count;
   logic [10:0] strobeVec;
   int nChecks = 0, nPass = 0, expCycle = 0, expRetire = 0;
   always #5 clk = ~clk;
   assign strobeVec = {fetch_en, decode_en, exec_en, mem_en, mem_read_not_write, wb_en,
                       rf_write_en, cpsr_write_en, pc_inc, pc_branch, fault};
   cpu_stage_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(16)) dut (
      .clk(clk), .nreset(nreset), .halt_req(halt_req), .imem_ready(imem_ready),
      .dmem_ready(dmem_ready), .cond_pass(cond_pass), .dec_is_branch(dec_is_branch),
      .dec_is_mem(dec_is_mem), .dec_is_load(dec_is_load), .dec_writes_rd(dec_writes_rd),
      .dec_set_flags(dec_set_flags), .fetch_en(fetch_en), .decode_en(decode_en),
      .exec_en(exec_en), .mem_en(mem_en), .mem_read_not_write(mem_read_not_write),
      .wb_en(wb_en), .rf_write_en(rf_write_en), .cpsr_write_en(cpsr_write_en),
      .pc_inc(pc_inc), .pc_branch(pc_branch), .state(state), .fault(fault),
      .cycle_count(cycle_count), .retire_count(retire_count)
   );
   task automatic check(input string tag, input int got, input int exp);
      nChecks++;
      if (got == exp) nPass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask
   task automatic noise();
      {halt_req, imem_ready, dmem_ready, cond_pass, dec_is_branch, dec_is_mem,
       dec_is_load, dec_writes_rd, dec_set_flags} = 9'($urandom);
   endtask
   // inputs are already driven; compare this cycle's outputs, then advance the model past the edge
   task automatic stepCheck(input string tag, input int st, input logic [10:0] sv, input bit ret);
      #1;
      check({tag, " state"}, int'(state), st);
      check({tag, " strobes"}, int'(strobeVec), int'(sv));
      check({tag, " cycle_count"}, int'(cycle_count), expCycle % 65536);
      check({tag, " retire_count"}, int'(retire_count), expRetire % 65536);
      if (st != 0 && st != 7) expCycle++;
      if (ret) expRetire++;
      @(negedge clk);
   endtask
   task automatic resetDut();
      nreset = 0;
      noise();
      #3;
      check("reset state", int'(state), 0);
      check("reset strobes", int'(strobeVec), 0);
      @(negedge clk);
      nreset = 1;
      expCycle = 0;
      expRetire = 0;
      noise(); halt_req = 1; stepCheck("idle hold", 0, 0, 0);
      noise(); halt_req = 0; stepCheck("idle go", 0, 0, 0);
   endtask
   task automatic runInstr(input bit br, input bit mem, input bit ld, input bit wr, input bit sf,
                           input bit cond, input bit halt, input bit abortMem, input int fw, input int mw);
      int n;
      logic [10:0] wbVec;
      n = $urandom_range(0, 2);
      wbVec = W | ((wr && !(mem && !ld)) ? RF : 11'h0) | ((sf && !mem) ? CP : 11'h0) | (br ? PB : PI);
      for (int i = 0; i <= fw; i++) begin
         noise(); imem_ready = (i == fw); stepCheck("fetch", 1, F, 0);
      end
      noise();
      {dec_is_branch, dec_is_mem, dec_is_load, dec_writes_rd, dec_set_flags} = {br, mem, ld, wr, sf};
      stepCheck("decode", 2, D, 0);
      noise(); cond_pass = cond;
      if (!cond) halt_req = halt;
      stepCheck("execute", 3, cond ? E : (E | PI), !cond);
      if (cond && mem) begin
         for (int i = 0; i <= mw && i < TO; i++) begin
            noise(); dmem_ready = (i == mw);
            if (abortMem && i == 1) begin
               dmem_ready = 0;
               #1; check("abort pre state", int'(state), 4);
               #2; nreset = 0;
               #1; check("abort state", int'(state), 0);
               check("abort strobes", int'(strobeVec), 0);
               check("abort cycle_count", int'(cycle_count), 0);
               check("abort retire_count", int'(retire_count), 0);
               @(negedge clk);
               nreset = 1; expCycle = 0; expRetire = 0;
               noise(); halt_req = 0; stepCheck("idle after abort", 0, 0, 0);
               return;
            end
            stepCheck("memory", 4, M | (ld ? MR : 11'h0), 0);
         end
         if (mw >= TO) begin
            for (int i = 0; i < 3; i++) begin
               noise(); stepCheck("fault", 7, FL, 0);
            end
            resetDut();
            return;
         end
      end
      if (cond) begin
         noise(); halt_req = halt; stepCheck("writeback", 5, wbVec, 1);
      end
      if (halt) begin
         for (int i = 0; i < n; i++) begin
            noise(); halt_req = 1; stepCheck("halted", 0, 0, 0);
         end
         noise(); halt_req = 0; stepCheck("resume", 0, 0, 0);
      end
   endtask
   initial begin
      noise();
      resetDut();
      runInstr(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
      runInstr(0, 1, 1, 1, 0, 1, 0, 0, 0, 3);
      runInstr(0, 1, 0, 1, 1, 1, 0, 0, 1, 2);
      runInstr(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      runInstr(1, 0, 0, 0, 1, 1, 0, 0, 2, 0);
      runInstr(0, 0, 0, 1, 1, 1, 1, 0, 0, 0);
      runInstr(0, 1, 1, 1, 0, 0, 1, 0, 0, 0);
      runInstr(0, 1, 1, 1, 0, 1, 0, 0, 0, TO - 1);
      runInstr(0, 1, 1, 1, 0, 1, 0, 1, 0, 5);
      runInstr(0, 1, 0, 0, 0, 1, 0, 0, 0, TO);
      repeat (200) begin
         int fw, mw;
         logic [4:0] kind;
         kind = 5'($urandom);
         fw = $urandom_range(0, 3);
         mw = ($urandom_range(0, 9) == 0) ? $urandom_range(5, TO) : $urandom_range(0, 3);
         runInstr(kind[0], kind[1], kind[2], kind[3], kind[4],
                  $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 0, fw, mw);
      end
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end
endmodule

// File: doc/cpu_stage_sequencer.md
Name: cpu_stage_sequencer

Overview:
Multi-cycle control sequencer for the single-issue ARM datapath. It steps each instruction through fetch, register fetch, execute, data memory and writeback. It produces the per-stage latch enables, PC update strobes and register-file, CPSR and data-memory control. It waits on the instruction-memory and data-memory handshakes, skips condition-failed instructions and keeps cycle and retire counters for the debug ports.

Parameters:
MEM_TIMEOUT, 15, max cycles spent in MEMORY waiting for dmem_ready before entering FAULT (1..255)
CNT_W, 16, width of cycle_count and retire_count

Ports:
clk  input  1  system clock, rising edge
nreset  input  1  asynchronous active-low reset
halt_req  input  1  request to stop at the next instruction boundary
imem_ready  input  1  instruction word valid this cycle
dmem_ready  input  1  data memory access complete this cycle
cond_pass  input  1  condition test result, valid during EXECUTE
dec_is_branch  input  1  decoded B/BL, valid during DECODE
dec_is_mem  input  1  decoded LDR/STR, valid during DECODE
dec_is_load  input  1  decoded load (1) / store (0), valid during DECODE
dec_writes_rd  input  1  instruction writes a destination register, valid during DECODE
dec_set_flags  input  1  S bit, valid during DECODE
fetch_en  output  1  latch instruction register
decode_en  output  1  latch decode fields and register-file read data
exec_en  output  1  latch ALU/shifter result
mem_en  output  1  data memory access enable
mem_read_not_write  output  1  1 = read, 0 = write; qualified by mem_en
wb_en  output  1  writeback stage active
rf_write_en  output  1  register-file write strobe
cpsr_write_en  output  1  CPSR flag write strobe
pc_inc  output  1  PC <= PC+4 strobe
pc_branch  output  1  PC <= branch target strobe
state  output  3  current state encoding
fault  output  1  sticky memory-timeout flag
cycle_count  output  CNT_W  active cycles since reset
retire_count  output  CNT_W  instructions completed, including skipped ones

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, FAULT=7.
- Async reset, on nreset low at any time including mid-instruction:
  - state=IDLE; internal flags and wait counter cleared.
  - fault=0, cycle_count=0, retire_count=0.
  - All strobe outputs 0.
- Stage enables fetch_en/decode_en/exec_en/mem_en/wb_en are Moore outputs. Each is 1 only in its own state.
- IDLE: all strobes 0. Next state FETCH if halt_req=0, else stay.
- FETCH: fetch_en=1. Stays in FETCH while imem_ready=0. Goes to DECODE on the cycle imem_ready=1.
- DECODE: decode_en=1. At exit, latches dec_is_branch/is_mem/is_load/writes_rd/set_flags into internal flags, which are held stable until the next DECODE. Always goes to EXECUTE.
- EXECUTE: exec_en=1.
  - cond_pass=0: skip the instruction. pc_inc=1 this cycle (Mealy), retire_count+1, next state FETCH (IDLE if halt_req=1). No rf/cpsr/mem strobes.
  - cond_pass=1 and is_mem=1: next state MEMORY.
  - cond_pass=1 and is_mem=0: next state WRITEBACK.
- MEMORY: mem_en=1, mem_read_not_write=latched is_load.
  - A wait counter clears on entry and increments each cycle dmem_ready=0.
  - dmem_ready=1: go to WRITEBACK, same cycle as the ready.
  - Counter reaches MEM_TIMEOUT with dmem_ready still 0: go to FAULT.
- WRITEBACK: lasts exactly 1 cycle.
  - wb_en=1.
  - rf_write_en = latched writes_rd AND NOT (is_mem AND NOT is_load). A store never writes the register file.
  - cpsr_write_en = latched set_flags AND NOT is_mem.
  - pc_branch = latched is_branch; pc_inc = NOT is_branch. Exactly one of the two is 1.
  - retire_count+1.
  - Next state FETCH, or IDLE if halt_req=1.
- FAULT:
  - fault=1 and held. All strobes 0.
  - Counters frozen.
  - Stays in FAULT until reset.
- halt_req is sampled only at instruction boundaries (WRITEBACK exit, skip exit, IDLE). A mid-instruction assertion never aborts the instruction.
- cycle_count increments every cycle state is not IDLE or FAULT.
- Both counters wrap modulo 2^CNT_W without saturation.
- pc_inc and pc_branch are never both 1. At most one PC strobe per instruction.

Test Plan:
- ALU instr, imem_ready=1, cond_pass=1, writes_rd=1, reset released before cycle 0 -> states IDLE,FETCH,DECODE,EXECUTE,WRITEBACK,FETCH on cycles 0-5. rf_write_en=1 and pc_inc=1 only in cycle 4. retire_count=1, cycle_count=4 at cycle 5.
- LDR with dmem_ready low for 3 MEMORY cycles -> MEMORY held 4 cycles with mem_read_not_write=1, then WRITEBACK with rf_write_en=1. STR -> mem_read_not_write=0 and rf_write_en=0.
- Condition-failed branch (cond_pass=0, is_branch=1) -> EXECUTE goes straight to FETCH. pc_inc=1, pc_branch=0, no rf/cpsr/mem strobes, retire_count+1.
- Taken branch with set_flags=1 -> WRITEBACK gives pc_branch=1, pc_inc=0, cpsr_write_en=1.
- dmem_ready held 0 with MEM_TIMEOUT=15 -> FAULT entered after 15 wait cycles. fault=1, counters frozen, state=7 held until nreset pulse, then state=0 and counters=0.
- halt_req raised during EXECUTE -> instruction completes, then IDLE. Drop halt_req -> FETCH next cycle. nreset pulsed mid-MEMORY -> immediate IDLE, mem_en=0 asynchronously.
